// File: rtl/swt16_pkg.sv
// Shared constants for the swt16 core: the NOP encoding and default
// fetch geometry used by the prefetch unit and its neighbours.
package swt16_pkg;

  localparam logic [15:0] NOP_INSTR            = 16'h0000;
  localparam int          PC_INCREMENT_DEFAULT = 2;
  localparam int          QUEUE_DEPTH_DEFAULT  = 4;

  // Width of an occupancy counter that must be able to hold 0..depth.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Generic synchronous FIFO with a synchronous clear and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module prefetch_fifo
  import swt16_pkg::*;
#(
  parameter  int WIDTH = 28,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = countWidth(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Clear wins over everything; pushes into full and pops from empty are dropped.
  assign do_push = push_i && !full && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: streams sequential PMEM reads into a small queue
// feeding decode. Define PREFETCH_BYPASS_EN to let a response skip an empty queue.
module prefetch_unit
  import swt16_pkg::*;
#(
  parameter  int PC_WIDTH     = 12,
  parameter  int PMEM_WIDTH   = 16,
  parameter  int PC_INCREMENT = PC_INCREMENT_DEFAULT,
  parameter  int QUEUE_DEPTH  = QUEUE_DEPTH_DEFAULT,
  localparam int CNT_W        = countWidth(QUEUE_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_set_pc,
  input  logic [PC_WIDTH-1:0]   in_branch_pc,
  output logic [PC_WIDTH-1:0]   out_pmem_addr,
  output logic                  out_pmem_req,
  input  logic [PMEM_WIDTH-1:0] in_instr,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [PMEM_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [CNT_W-1:0]      out_count
);

  localparam int ENTRY_W = PC_WIDTH + PMEM_WIDTH;
  localparam int OCC_W   = CNT_W + 1;

  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic                  pending_q, pending_d;
  logic [OCC_W-1:0]      occupancy;
  logic                  issue;
  logic                  bypass_hit;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    head_entry;
  logic [PC_WIDTH-1:0]   head_pc;
  logic [PMEM_WIDTH-1:0] head_instr;
  logic                  empty;
  logic [CNT_W-1:0]      count;

  // The in-flight read counts against capacity, so the queue can never overflow.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pending_q};
  assign issue     = reset && !in_set_pc && (occupancy < OCC_W'(QUEUE_DEPTH));

  assign out_pmem_req  = issue;
  assign out_pmem_addr = fetch_pc_q;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = empty && pending_q && !in_set_pc;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_pc    = head_entry[ENTRY_W-1 -: PC_WIDTH];
  assign head_instr = head_entry[PMEM_WIDTH-1:0];

  assign out_valid = !in_set_pc && (!empty || bypass_hit);
  assign pop       = !in_set_pc && !empty && in_ready;
  assign push      = pending_q && !in_set_pc && !(bypass_hit && in_ready);
  assign out_count = count;

  always_comb begin
    out_instr = PMEM_WIDTH'(NOP_INSTR);
    out_pc    = '0;
    if (!empty) begin
      out_instr = head_instr;
      out_pc    = head_pc;
    end else if (bypass_hit) begin
      out_instr = in_instr;
      out_pc    = pend_pc_q;
    end
  end

  // A redirect discards the outstanding response and restarts fetch at the target.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = pending_q;
    if (in_set_pc) begin
      fetch_pc_d = in_branch_pc;
      pending_d  = 1'b0;
    end else begin
      pending_d = issue;
      if (issue) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_INCREMENT);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= '0;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (in_set_pc),
    .push_i  (push),
    .data_i  ({pend_pc_q, in_instr}),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (count),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit: a PMEM model answers reads, a PC-stream
// model predicts every delivered {pc, instr}, a monitor checks each handshake.
module tb_prefetch_unit;

  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam int RESET_LAT = 1;
  localparam int REDIR_LAT = 2;
`else
  localparam int RESET_LAT = 2;
  localparam int REDIR_LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_set_pc;
  logic [11:0] in_branch_pc;
  logic [11:0] out_pmem_addr;
  logic        out_pmem_req;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        in_ready;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic [2:0]  out_count;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] model_pc;
  int          total = 0;
  int          bad = 0;
  int          deliv_cnt = 0;

  prefetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .in_set_pc     (in_set_pc),
    .in_branch_pc  (in_branch_pc),
    .out_pmem_addr (out_pmem_addr),
    .out_pmem_req  (out_pmem_req),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .in_ready      (in_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_count     (out_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] pmemWord(input logic [11:0] a);
    logic [15:0] w;
    w = ({4'h0, a} * 16'h9E37) ^ 16'h5A5A;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic topUp();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: model_pc, instr: pmemWord(model_pc)});
      model_pc = model_pc + 12'd2;
    end
  endtask

  task automatic startStream(input logic [11:0] pc);
    exp_q.delete();
    model_pc = pc;
    topUp();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    topUp();
  endtask

  task automatic applyStimulus(input logic rst, input logic setpc, input logic [11:0] br, input logic rdy);
    reset        = rst;
    in_set_pc    = setpc;
    in_branch_pc = br;
    in_ready     = rdy;
  endtask

  task automatic resetAndRelease(input logic rdy);
    tick();
    applyStimulus(1'b0, 1'b0, 12'h0, rdy);
    tick();
    tick();
    reset = 1'b1;
    startStream(12'h0);
  endtask

  task automatic waitDeliveries(input int n, input int budget);
    int target;
    int c;
    target = deliv_cnt + n;
    c = 0;
    while (deliv_cnt < target && c < budget) begin
      tick();
      c++;
    end
    checkOutput("deliveries_reached", 32'(deliv_cnt >= target), 32'd1);
  endtask

  // Called right after the redirect cycle has been clocked in.
  task automatic measureRedirect(input logic [11:0] target);
    int first;
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checkOutput("redir_req", 32'(out_pmem_req), 32'd1);
        checkOutput("redir_addr", 32'(out_pmem_addr), 32'(target));
      end
      if (out_valid && first < 0) first = k;
    end
    checkOutput("redir_latency", 32'(first), 32'(REDIR_LAT));
  endtask

  // PMEM model: answers the read seen in one cycle during the next cycle.
  initial begin
    logic        pm_req;
    logic [11:0] pm_addr;
    in_instr = 16'h0;
    forever begin
      @(negedge clock);
      pm_req  = out_pmem_req;
      pm_addr = out_pmem_addr;
      @(posedge clock);
      #1;
      in_instr = pm_req ? pmemWord(pm_addr) : 16'($urandom);
    end
  end

  // Monitor: every accepted head must be the next entry of the model stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        checkOutput("count_bound", 32'(out_count <= 3'(DEPTH)), 32'd1);
        if (out_valid && in_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_pc", 32'(out_pc), 32'(e.pc));
            checkOutput("out_instr", 32'(out_instr), 32'(e.instr));
          end
          deliv_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int first;
    int nreq;
    bit found;
    applyStimulus(1'b0, 1'b0, 12'h0, 1'b1);
    model_pc = 12'h0;

    // Reset values
    tick();
    tick();
    @(negedge clock);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_req", 32'(out_pmem_req), 32'd0);
    checkOutput("rst_count", 32'(out_count), 32'd0);
    checkOutput("rst_instr", 32'(out_instr), 32'(swt16_pkg::NOP_INSTR));
    checkOutput("rst_pc", 32'(out_pc), 32'd0);

    // Release with decode always ready: reads at 0,2,4,6 back to back
    tick();
    reset = 1'b1;
    startStream(12'h0);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k < 4) begin
        checkOutput("seq_req", 32'(out_pmem_req), 32'd1);
        checkOutput("seq_addr", 32'(out_pmem_addr), 32'(2 * k));
      end
      if (out_valid && first < 0) first = k;
    end
    checkOutput("reset_latency", 32'(first), 32'(RESET_LAT));
    waitDeliveries(3, 20);

    // Stalled decode: exactly DEPTH reads, then silence
    resetAndRelease(1'b0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_pmem_req) begin
        checkOutput("stall_addr", 32'(out_pmem_addr), 32'(2 * nreq));
        nreq++;
      end
    end
    checkOutput("stall_nreq", 32'(nreq), 32'(DEPTH));
    checkOutput("stall_count", 32'(out_count), 32'(DEPTH));
    checkOutput("stall_no_req", 32'(out_pmem_req), 32'd0);
    tick();
    in_ready = 1'b1;
    waitDeliveries(6, 40);

    // Reset mid-stream with two entries queued
    resetAndRelease(1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (out_count == 3'd2) found = 1'b1;
    end
    checkOutput("fill_to_2", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_count", 32'(out_count), 32'd0);
    checkOutput("midrst_req", 32'(out_pmem_req), 32'd0);
    startStream(12'h0);
    tick();
    tick();
    reset = 1'b1;
    in_ready = 1'b1;
    @(negedge clock);
    checkOutput("restart_req", 32'(out_pmem_req), 32'd1);
    checkOutput("restart_addr", 32'(out_pmem_addr), 32'd0);
    waitDeliveries(4, 30);

    // Redirect to 0x100 with three queued entries and a read outstanding
    resetAndRelease(1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (out_count == 3'd3) found = 1'b1;
    end
    checkOutput("fill_to_3", 32'(found), 32'd1);
    in_set_pc    = 1'b1;
    in_branch_pc = 12'h100;
    #1;
    checkOutput("redir_valid_low", 32'(out_valid), 32'd0);
    startStream(12'h100);
    tick();
    in_set_pc = 1'b0;
    in_ready  = 1'b1;
    measureRedirect(12'h100);
    waitDeliveries(3, 20);

    // Redirect near the top of the address space: 0xFFE, 0x000, 0x002
    tick();
    in_set_pc    = 1'b1;
    in_branch_pc = 12'hFFE;
    startStream(12'hFFE);
    @(negedge clock);
    checkOutput("wrap_valid_low", 32'(out_valid), 32'd0);
    tick();
    in_set_pc = 1'b0;
    measureRedirect(12'hFFE);
    waitDeliveries(3, 20);

    // Random back-pressure with occasional redirects
    first = deliv_cnt;
    for (int k = 0; k < 1000; k++) begin
      tick();
      in_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        in_set_pc    = 1'b1;
        in_branch_pc = 12'($urandom) & 12'hFFE;
        startStream(in_branch_pc);
      end else begin
        in_set_pc = 1'b0;
      end
    end
    tick();
    in_set_pc = 1'b0;
    in_ready  = 1'b1;
    waitDeliveries(4, 40);
    checkOutput("random_progress", 32'(deliv_cnt - first > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 12: program-counter and PMEM address width.
REQ-002 SHALL have parameter PMEM_WIDTH, default 16: instruction word width.
REQ-003 SHALL have parameter PC_INCREMENT, default 2: sequential PC step.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4: prefetch entries; power of two, >= 2.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_set_pc  in  1  redirect request from EX.
REQ-008 SHALL have port in_branch_pc  in  PC_WIDTH  redirect target.
REQ-009 SHALL have port out_pmem_addr  out  PC_WIDTH  PMEM read address.
REQ-010 SHALL have port out_pmem_req  out  1  read issued this cycle.
REQ-011 SHALL have port in_instr  in  PMEM_WIDTH  PMEM word; valid the cycle after a request.
REQ-012 SHALL have port out_valid  out  1  head entry presented to DC.
REQ-013 SHALL have port in_ready  in  1  DC accepts head.
REQ-014 SHALL have port out_instr  out  PMEM_WIDTH  head instruction.
REQ-015 SHALL have port out_pc  out  PC_WIDTH  head PC.
REQ-016 SHALL have port out_count  out  clog2(QUEUE_DEPTH+1)  occupied entries.

Function
REQ-017 SHALL issue a read (out_pmem_req=1, out_pmem_addr=fetch PC) when count + pending < QUEUE_DEPTH and in_set_pc=0; fetch PC then advances by PC_INCREMENT, wrapping modulo 2^PC_WIDTH.
REQ-018 SHALL hold one pending flag; the response of a request in cycle t SHALL be pushed as {pc, in_instr} at the end of cycle t+1.
REQ-019 SHALL pop head at the edge where out_valid && in_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 SHALL assert out_valid iff count > 0 and in_set_pc=0; out_instr/out_pc SHALL reflect the head entry.
REQ-021 SHALL never overflow: a push into a full queue is impossible by REQ-017; a pop from empty SHALL be ignored.
REQ-022 On in_set_pc: queue cleared, pending response discarded (not pushed), fetch PC := in_branch_pc; the first request to in_branch_pc SHALL issue in cycle t+1, out_valid in t+3.
REQ-023 in_set_pc SHALL dominate simultaneous pop, push and issue.
REQ-024 Read/write pointers SHALL wrap modulo QUEUE_DEPTH.

Reset
REQ-025 While reset=0: fetch PC=0, count=0, pointers=0, pending=0, out_valid=0, out_pmem_req=0, out_instr=NOP_INSTR, out_pc=0.
REQ-026 First request (address 0) SHALL issue in the first cycle after reset deasserts; reset mid-stream SHALL drop all entries and any pending response.

Configuration
REQ-027 With PREFETCH_BYPASS_EN defined: when the queue is empty and a valid response arrives, it SHALL be presented on out_valid/out_instr/out_pc the same cycle, and not enqueued if popped; redirect-to-out_valid latency becomes 2 cycles.
REQ-028 Without PREFETCH_BYPASS_EN: all responses pass through the queue; latency per REQ-022.

Structure
REQ-029 NOP_INSTR and the PC_INCREMENT default SHALL reside in the shared swt16_pkg constants.
REQ-030 Storage SHALL be one sub-module prefetch_fifo (generic synchronous FIFO, width PC_WIDTH+PMEM_WIDTH, depth QUEUE_DEPTH, with clear).

Verification
REQ-031 Reset release, in_ready=1 -> requests at addr 0,2,4,...; out_valid from cycle 2 (bypass: 1) with out_pc 0,2,4 in order.
REQ-032 in_ready=0 for 10 cycles -> exactly 4 requests issued, out_count=4, no further out_pmem_req; releasing in_ready drains PCs 0,2,4,6 then resumes at 8.
REQ-033 in_set_pc with in_branch_pc=0x100 while queue holds 3 entries and one pending -> out_valid=0 that cycle, next request addr 0x100, stale word never appears, next out_pc=0x100.
REQ-034 in_branch_pc=0xFFE, PC_WIDTH=12 -> out_pc sequence 0xFFE, 0x000, 0x002.
REQ-035 Assert reset with 2 entries queued -> out_valid=0, out_count=0 immediately; after release, fetch restarts at 0.
REQ-036 Random in_ready toggling for 1000 cycles -> delivered PCs strictly sequential, no drop or duplicate, out_count never exceeds 4.
